// File: rtl/ecc_arbiter_if.sv
// Requester/core bundle for ecc_arbiter. The slave side is the arbiter. The master side is the
// controller plus the core, and it drives req/operands and edone/result.
interface ecc_arbiter_if #(
  parameter int W = 164
);
  logic         req0, req1;
  logic [W-1:0] k0, k1, px0, py0, px1, py1;
  logic         ack0, ack1, err0, err1;
  logic [W-1:0] rx, ry;
  logic         busy, owner;
  logic         estart;
  logic [W-1:0] ek, ebx, eby;
  logic         edone;
  logic [W-1:0] eox, eoy;

  modport slave (
    input  req0, req1, k0, k1, px0, py0, px1, py1, edone, eox, eoy,
    output ack0, ack1, err0, err1, rx, ry, busy, owner, estart, ek, ebx, eby
  );

  modport master (
    output req0, req1, k0, k1, px0, py0, px1, py1, edone, eox, eoy,
    input  ack0, ack1, err0, err1, rx, ry, busy, owner, estart, ek, ebx, eby
  );
endinterface

// File: rtl/ecc_arbiter.sv
// Round-robin share of one ECC point-multiplier between two requesters, with a watchdog abort.
// Grant takes 1 cycle and the result arrives 1 cycle after edone; requests wait in IDLE while a job runs.
module ecc_arbiter #(
  parameter int W       = 164,
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  ecc_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR, COOL} state_t;

  typedef struct packed {
    logic [W-1:0] k;
    logic [W-1:0] bx;
    logic [W-1:0] by;
  } opnd_t;

  state_t          state_q, state_d;
  opnd_t           opnd_q, opnd_sel;
  logic            last_q, owner_q, gnt_id;
  logic [W-1:0]    rx_q, ry_q;
  logic [TO_W-1:0] cnt_q;
  logic            ack0_q, ack1_q, err0_q, err1_q;
  logic            estart_q, busy_q;
  logic            wd_exp;

  // When both ports request, the one not served last time wins.
  assign gnt_id = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign wd_exp = (cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    opnd_sel = '{k: bus.k0, bx: bus.px0, by: bus.py0};
    if (gnt_id)
      opnd_sel = '{k: bus.k1, bx: bus.px1, by: bus.py1};
    case (state_q)
      IDLE:      if (bus.req0 || bus.req1) state_d = LOAD;
      LOAD:      state_d = RUN;
      RUN: begin
        if (bus.edone)   state_d = DONE;
        else if (wd_exp) state_d = ERR;
      end
      DONE, ERR: state_d = COOL;
      COOL:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      opnd_q   <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      rx_q     <= '0;
      ry_q     <= '0;
      cnt_q    <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      estart_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      // Flags are decoded from the next state so they line up with that state.
      estart_q <= (state_d == RUN);
      busy_q   <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (state_d == LOAD) begin
            opnd_q  <= opnd_sel;
            owner_q <= gnt_id;
            last_q  <= gnt_id;
          end
        end
        LOAD: cnt_q <= '0;
        RUN: begin
          cnt_q <= cnt_q + TO_W'(1);
          if (state_d == DONE) begin
            rx_q   <= bus.eox;
            ry_q   <= bus.eoy;
            ack0_q <= ~owner_q;
            ack1_q <= owner_q;
          end else if (state_d == ERR) begin
            err0_q <= ~owner_q;
            err1_q <= owner_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ek     = opnd_q.k;
  assign bus.ebx    = opnd_q.bx;
  assign bus.eby    = opnd_q.by;
  assign bus.rx     = rx_q;
  assign bus.ry     = ry_q;
  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.err0   = err0_q;
  assign bus.err1   = err1_q;
  assign bus.estart = estart_q;
  assign bus.busy   = busy_q;
  assign bus.owner  = owner_q;

endmodule

// File: tb/tb_ecc_arbiter.sv
// Bench for ecc_arbiter: it applies a vector table, randomized jobs checked against a transaction-level model,
// and a mid-job reset.
module tb_ecc_arbiter;
  localparam int W  = 164;
  localparam int TO = 24;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  ecc_arbiter_if #(.W(W)) bus();

  ecc_arbiter #(.W(W), .TIMEOUT(TO), .TO_W(5)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int           checks = 0;
  int           errors = 0;
  int           core_delay = 0;
  int           run_cnt = 0;
  bit           stray_en = 1'b0;
  logic [W-1:0] core_x = '0;
  logic [W-1:0] core_y = '0;

  typedef struct {
    bit          r0, r1;
    int unsigned k0, k1;
    int          delay;
    int unsigned cx, cy;
    bit          w;
    bit          ack;
    int          lat;
    int unsigned ek, rx, ry;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v = {v[W-33:0], $urandom()};
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic reset_chk(input string tag);
    chk1({"busy_", tag}, bus.busy, 1'b0);
    chk1({"estart_", tag}, bus.estart, 1'b0);
    chk1({"owner_", tag}, bus.owner, 1'b0);
    chk({"pulses_", tag}, W'({bus.ack0, bus.ack1, bus.err0, bus.err1}), '0);
    chk({"ek_", tag}, bus.ek, '0);
    chk({"ebx_", tag}, bus.ebx, '0);
    chk({"eby_", tag}, bus.eby, '0);
    chk({"rx_", tag}, bus.rx, '0);
    chk({"ry_", tag}, bus.ry, '0);
  endtask

  // Core model: edone fires on the core_delay-th cycle that estart is seen high (0 = never).
  initial begin
    bus.edone = 1'b0;
    bus.eox   = '0;
    bus.eoy   = '0;
    forever begin
      @(negedge clk);
      if (bus.estart === 1'b1) begin
        run_cnt++;
        bus.edone = (run_cnt == core_delay);
        bus.eox   = core_x;
        bus.eoy   = core_y;
      end else begin
        run_cnt   = 0;
        bus.edone = stray_en && ($urandom_range(0, 3) == 0);
        bus.eox   = rnd_w();
        bus.eoy   = rnd_w();
      end
    end
  end

  // One job from IDLE: requests are already driven. The winner's operands are scrambled after grant.
  task automatic run_job(input bit w, input bit exp_ack, input int exp_lat,
                         input logic [W-1:0] ek_e, input logic [W-1:0] ebx_e, input logic [W-1:0] eby_e,
                         input logic [W-1:0] rx_e, input logic [W-1:0] ry_e);
    bit       seen;
    logic [3:0] exp_p;
    seen  = 1'b0;
    exp_p = exp_ack ? (w ? 4'b0100 : 4'b1000) : (w ? 4'b0001 : 4'b0010);
    @(negedge clk);
    chk1("owner_grant", bus.owner, w);
    chk1("busy_load", bus.busy, 1'b1);
    chk1("estart_load", bus.estart, 1'b0);
    chk("ek_grant", bus.ek, ek_e);
    chk("ebx_grant", bus.ebx, ebx_e);
    chk("eby_grant", bus.eby, eby_e);
    if (w) begin
      bus.k1 = rnd_w(); bus.px1 = rnd_w(); bus.py1 = rnd_w();
    end else begin
      bus.k0 = rnd_w(); bus.px0 = rnd_w(); bus.py0 = rnd_w();
    end
    for (int n = 2; n <= TO + 8 && !seen; n++) begin
      @(negedge clk);
      if (n == 2) chk1("estart_run", bus.estart, 1'b1);
      if (bus.ack0 || bus.ack1 || bus.err0 || bus.err1) begin
        seen = 1'b1;
        chk("latency", W'(n), W'(exp_lat));
        chk("pulse", W'({bus.ack0, bus.ack1, bus.err0, bus.err1}), W'(exp_p));
        chk("rx", bus.rx, rx_e);
        chk("ry", bus.ry, ry_e);
        chk("ek_hold", bus.ek, ek_e);
        chk("ebx_hold", bus.ebx, ebx_e);
        chk("eby_hold", bus.eby, eby_e);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no ack/err within %0d cycles, want latency %0d", TO + 8, exp_lat);
    end
    if (w) bus.req1 = 1'b0;
    else   bus.req0 = 1'b0;
    @(negedge clk);
    chk("pulse_cool", W'({bus.ack0, bus.ack1, bus.err0, bus.err1}), '0);
    chk1("estart_cool", bus.estart, 1'b0);
    chk1("busy_cool", bus.busy, 1'b1);
    @(negedge clk);
    chk1("busy_idle", bus.busy, 1'b0);
    chk1("owner_idle", bus.owner, w);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit           m_last;
    bit   [1:0]   pend;
    logic [W-1:0] m_rx, m_ry;
    logic [W-1:0] mk [2];
    logic [W-1:0] mx [2];
    logic [W-1:0] my [2];
    bit           w, ack;
    int           d;

    //            r0 r1 k0 k1 dly cx      cy      w  ack lat ek  rx      ry
    tbl[0] = '{1, 0,  5,  7, 20, 'hABC, 'h123, 0, 1, 22,  5, 'hABC, 'h123};
    tbl[1] = '{0, 1,  9, 11,  3, 'h111, 'h222, 1, 1,  5, 11, 'h111, 'h222};
    tbl[2] = '{1, 1, 20, 21, TO, 'h333, 'h444, 0, 1, TO+2, 20, 'h333, 'h444};
    tbl[3] = '{0, 1,  0, 21,  0, 'hBAD, 'hBAD, 1, 0, TO+2, 21, 'h333, 'h444};
    tbl[4] = '{1, 1, 30, 31,  5, 'h555, 'h666, 0, 1,  7, 30, 'h555, 'h666};
    tbl[5] = '{0, 1,  0, 31,  1, 'h777, 'h888, 1, 1,  3, 31, 'h777, 'h888};
    tbl[6] = '{1, 0, 40,  0, TO+1, 'hBAD, 'hBAD, 0, 0, TO+2, 40, 'h777, 'h888};
    tbl[7] = '{1, 0, 50,  0,  2, 'h999, 'hAAA, 0, 1,  4, 50, 'h999, 'hAAA};

    n_rst = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.k0 = '0; bus.k1 = '0; bus.px0 = '0; bus.py0 = '0; bus.px1 = '0; bus.py1 = '0;
    repeat (3) @(negedge clk);
    reset_chk("reset");
    n_rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      bus.req0 = tbl[i].r0;
      bus.req1 = tbl[i].r1;
      bus.k0  = W'(tbl[i].k0);
      bus.px0 = W'(tbl[i].k0 + 32'h1000);
      bus.py0 = W'(tbl[i].k0 + 32'h2000);
      bus.k1  = W'(tbl[i].k1);
      bus.px1 = W'(tbl[i].k1 + 32'h1000);
      bus.py1 = W'(tbl[i].k1 + 32'h2000);
      core_delay = tbl[i].delay;
      core_x = W'(tbl[i].cx);
      core_y = W'(tbl[i].cy);
      run_job(tbl[i].w, tbl[i].ack, tbl[i].lat, W'(tbl[i].ek), W'(tbl[i].ek + 32'h1000),
              W'(tbl[i].ek + 32'h2000), W'(tbl[i].rx), W'(tbl[i].ry));
    end

    // Randomized jobs. A losing requester keeps its request and operands until it is served.
    m_last = 1'b0;
    m_rx = W'(tbl[7].rx);
    m_ry = W'(tbl[7].ry);
    pend = 2'b00;
    for (int p = 0; p < 2; p++) begin
      mk[p] = '0; mx[p] = '0; my[p] = '0;
    end
    stray_en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
          pend[p] = 1'b1; mk[p] = rnd_w(); mx[p] = rnd_w(); my[p] = rnd_w();
        end
      end
      if (pend == 2'b00) begin
        d = $urandom_range(0, 1);
        pend[d] = 1'b1; mk[d] = rnd_w(); mx[d] = rnd_w(); my[d] = rnd_w();
      end
      bus.req0 = pend[0]; bus.k0 = mk[0]; bus.px0 = mx[0]; bus.py0 = my[0];
      bus.req1 = pend[1]; bus.k1 = mk[1]; bus.px1 = mx[1]; bus.py1 = my[1];
      w   = (pend == 2'b11) ? !m_last : pend[1];
      d   = $urandom_range(0, TO + 4);
      ack = (d >= 1) && (d <= TO);
      core_delay = d;
      core_x = rnd_w();
      core_y = rnd_w();
      run_job(w, ack, ack ? d + 2 : TO + 2, mk[w], mx[w], my[w],
              ack ? core_x : m_rx, ack ? core_y : m_ry);
      m_last  = w;
      pend[w] = 1'b0;
      if (ack) begin
        m_rx = core_x; m_ry = core_y;
      end
    end
    stray_en = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of RUN: the job is discarded, and the first tie afterwards goes to port 0.
    core_delay = 0;
    bus.req0 = 1'b1;
    bus.k0 = rnd_w();
    repeat (5) @(negedge clk);
    chk1("estart_pre_rst", bus.estart, 1'b1);
    n_rst = 1'b0;
    bus.req1 = 1'b1;
    @(negedge clk);
    reset_chk("mid_rst");
    repeat (2) @(negedge clk);
    reset_chk("held_rst");
    bus.k0 = W'(32'h77); bus.px0 = W'(32'h1077); bus.py0 = W'(32'h2077);
    bus.k1 = W'(32'h88); bus.px1 = W'(32'h1088); bus.py1 = W'(32'h2088);
    core_delay = 3;
    core_x = W'(32'hC0FFEE);
    core_y = W'(32'hBEEF);
    n_rst = 1'b1;
    run_job(1'b0, 1'b1, 5, W'(32'h77), W'(32'h1077), W'(32'h2077), W'(32'hC0FFEE), W'(32'hBEEF));
    core_delay = 2;
    core_x = W'(32'h1234);
    core_y = W'(32'h5678);
    run_job(1'b1, 1'b1, 4, W'(32'h88), W'(32'h1088), W'(32'h2088), W'(32'h1234), W'(32'h5678));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ecc_arbiter.md
# ecc_arbiter

Shares the single ECC point-multiplier core between two requesters: port 0 for local public-key generation and port 1 for peer shared-secret agreement. The block arbitrates round-robin and latches the winner's scalar and base point. It sequences the core's `estart`/`edone` handshake, captures the result, and returns it with a one-cycle acknowledge. A watchdog aborts hung operations. The block sits between the top-level controller and the ECC core.

## Interface
Parameters:
- `W`, 164, coordinate/scalar width
- `TIMEOUT`, 65535, maximum RUN cycles before abort (must be ≥2)
- `TO_W`, 16, watchdog counter width (TIMEOUT < 2^TO_W)

Ports:
- `clk`  in  1  single clock, rising edge
- `n_rst`  in  1  reset, synchronous, active-low
- `req0`, `req1`  in  1  level request; held until matching `ack`/`err`
- `k0`, `k1`  in  W  scalar per requester
- `px0`, `py0`, `px1`, `py1`  in  W  base point per requester
- `ack0`, `ack1`  out  1  one-cycle pulse, result valid on `rx`/`ry`
- `err0`, `err1`  out  1  one-cycle pulse, operation aborted by watchdog
- `rx`, `ry`  out  W  last captured result (shared by both requesters)
- `busy`  out  1  high in every state except IDLE
- `owner`  out  1  requester currently granted; last granted while IDLE
- `estart`  out  1  to core; high for the whole of RUN
- `ek`, `ebx`, `eby`  out  W  operands to core; stable from LOAD until next grant
- `edone`  in  1  from core; completion
- `eox`, `eoy`  in  W  result from core; valid when `edone`=1

## Operation
- States: IDLE, LOAD, RUN, DONE, ERR, COOL.
- IDLE
  - No request: stay.
  - One request: grant it.
  - Both requests: grant `!last`, where `last` is the last granted requester. `last` resets to 1, so port 0 wins the first tie.
  - On grant: latch the winner's `k`/`px`/`py` into `ek`/`ebx`/`eby`, set `owner`, set `last`, go to LOAD.
  - Requester operands are don't-care after the grant cycle.
- LOAD: one cycle; operands settle, `estart`=0; go to RUN; clear watchdog count.
- RUN
  - `estart`=1; watchdog increments each cycle.
  - `edone`=1: go to DONE. `edone` takes priority over watchdog expiry in the same cycle.
  - Otherwise, when count == TIMEOUT-1: go to ERR.
- DONE: `rx`←`eox`, `ry`←`eoy` (captured on entry edge); `ack[owner]`=1; go to COOL.
- ERR: `err[owner]`=1; `rx`/`ry` unchanged; go to COOL.
- COOL: one cycle, `estart`=0. This guarantees the core sees `estart` low between jobs. Go to IDLE.
- `edone` outside RUN is ignored.
- A request dropped after grant does not abort the job. The job completes, and `ack`/`err` still pulses.
- Reset (`n_rst`=0 at a clock edge) from any state:
  - Go to IDLE; `last`=1.
  - All outputs 0: `estart`, `ek`, `ebx`, `eby`, `rx`, `ry`, `ack*`, `err*`, `busy`, `owner`.
  - Watchdog count = 0.
  - An in-flight job is discarded with no `ack`/`err`.

## Timing
- Request sampled in IDLE at edge t0. LOAD spans t0→t1; `estart` rises after t1.
- `edone` sampled high at edge tn. `ack` and new `rx`/`ry` are visible tn→tn+1 (DONE). COOL spans tn+1→tn+2; IDLE from tn+2.
- Grant latency: 1 cycle. Result latency: 1 cycle after `edone`.
- Minimum turnaround per job beyond core time: 4 cycles (IDLE, LOAD, DONE, COOL).
- A requester must drop `req` within 1 cycle of seeing `ack`/`err`. If `req` is still high in IDLE, it is treated as a new request.
- Watchdog: `err` pulses exactly TIMEOUT+1 cycles after LOAD is entered, when `edone` never arrives.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single job: `req0`=1 with k0=5 and a base point; core model asserts `edone` 20 cycles after `estart` with eox=0xABC, eoy=0x123 → `ack0` single pulse, `rx`=0xABC, `ry`=0x123, `ack1`=0, `busy` low 2 cycles after `ack0`.
- Tie after reset: `req0`=`req1`=1 held → `owner`=0 first. Once `req0` drops, `owner`=1 and `ek`=k1. A second simultaneous tie grants 0 again (strict alternation).
- Operand isolation: change k0/px0/py0 the cycle after grant → `ek`/`ebx`/`eby` hold the grant-cycle values through RUN.
- Watchdog: TIMEOUT=8, core never asserts `edone` → `err0` pulses, `rx`/`ry` keep prior values, `estart` low in COOL, next request accepted.
- Priority edge: TIMEOUT=8, `edone` asserted on the 8th RUN cycle → `ack`, no `err`.
- Reset mid-RUN: pull `n_rst` low during RUN → next cycle IDLE, all outputs 0, no `ack`/`err`. The first post-reset tie is won by port 0.
